// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, phase encoding and coordinate type for the
// timing generator and the sprite/background mappers.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned COORD_W  = 10;

  typedef logic [COORD_W-1:0] vga_coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } vga_phase_t;

  // Phase a counter value belongs to, given the widths of the first three phases.
  function automatic vga_phase_t phase_of(input vga_coord_t cnt, input int unsigned active,
                                          input int unsigned fp, input int unsigned sync);
    if (32'(cnt) < active) return PH_ACTIVE;
    if (32'(cnt) < active + fp) return PH_FRONT;
    if (32'(cnt) < active + fp + sync) return PH_SYNC;
    return PH_BACK;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that resets to all-ones, used to align the
// active-low sync outputs with the mappers' registered colour path.
module sync_delay #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = vga_clk ^ reset_n;
    assign dout = din;
  end else if (DEPTH == 1) begin : g_one
    logic [WIDTH-1:0] q;
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) q <= '1;
      else          q <= din;
    end
    assign dout = q;
  end else begin : g_shift
    // Oldest sample sits in the top WIDTH bits.
    logic [DEPTH*WIDTH-1:0] pipe;
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) pipe <= '1;
      else          pipe <= {pipe[(DEPTH-1)*WIDTH-1:0], din};
    end
    assign dout = pipe[DEPTH*WIDTH-1 -: WIDTH];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel timing: free-running h/v counters, phase FSMs, registered
// blank/frame_start/line_end and SYNC_DLY-delayed active-low hs/vs.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned SYNC_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_end
);
  import vga_pkg::*;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_BACK_START = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_BACK_START = V_SYNC_START + V_SYNC;

  vga_coord_t hcnt, vcnt, hcnt_d, vcnt_d;
  vga_phase_t h_phase, v_phase, h_phase_d, v_phase_d;
  logic       armed;
  logic       h_wrap, v_adv;
  logic       blank_d, frame_start_d, line_end_d;
  logic [1:0] sync_raw, sync_raw_d, sync_out;

  // Next-state counters and phases; registered flags are decoded from the
  // next-state counters so they line up with the DrawX/DrawY they describe.
  always_comb begin
    hcnt_d        = hcnt + vga_coord_t'(1);
    vcnt_d        = vcnt;
    h_phase_d     = h_phase;
    v_phase_d     = v_phase;
    h_wrap        = (hcnt == vga_coord_t'(H_TOTAL - 1));
    v_adv         = h_wrap || !armed;
    blank_d       = 1'b0;
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;
    sync_raw_d    = 2'b11;

    if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = (vcnt == vga_coord_t'(V_TOTAL - 1)) ? '0 : vcnt + vga_coord_t'(1);
    end

    case (h_phase)
      PH_ACTIVE: if (32'(hcnt_d) >= H_ACTIVE)     h_phase_d = PH_FRONT;
      PH_FRONT:  if (32'(hcnt_d) >= H_SYNC_START) h_phase_d = PH_SYNC;
      PH_SYNC:   if (32'(hcnt_d) >= H_BACK_START) h_phase_d = PH_BACK;
      PH_BACK:   if (32'(hcnt_d) <  H_ACTIVE)     h_phase_d = PH_ACTIVE;
    endcase

    // The first cycle out of reset also advances, leaving the reset BACK state.
    if (v_adv) begin
      case (v_phase)
        PH_ACTIVE: if (32'(vcnt_d) >= V_ACTIVE)     v_phase_d = PH_FRONT;
        PH_FRONT:  if (32'(vcnt_d) >= V_SYNC_START) v_phase_d = PH_SYNC;
        PH_SYNC:   if (32'(vcnt_d) >= V_BACK_START) v_phase_d = PH_BACK;
        PH_BACK:   if (32'(vcnt_d) <  V_ACTIVE)     v_phase_d = PH_ACTIVE;
      endcase
    end

    blank_d       = (32'(hcnt_d) < H_ACTIVE) && (32'(vcnt_d) < V_ACTIVE);
    frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
    line_end_d    = (hcnt_d == vga_coord_t'(H_TOTAL - 1));
    sync_raw_d    = {h_phase_d != PH_SYNC, v_phase_d != PH_SYNC};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      h_phase     <= PH_BACK;
      v_phase     <= PH_BACK;
      armed       <= 1'b0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      sync_raw    <= 2'b11;
    end else begin
      hcnt        <= hcnt_d;
      vcnt        <= vcnt_d;
      h_phase     <= h_phase_d;
      v_phase     <= v_phase_d;
      armed       <= 1'b1;
      blank       <= blank_d;
      frame_start <= frame_start_d;
      line_end    <= line_end_d;
      sync_raw    <= sync_raw_d;
    end
  end

  assign DrawX = hcnt;
  assign DrawY = vcnt;

  sync_delay #(
    .WIDTH(2),
    .DEPTH(SYNC_DLY)
  ) u_sync_delay (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .din    (sync_raw),
    .dout   (sync_out)
  );

  assign hs = sync_out[1];
  assign vs = sync_out[0];

  // Phase registers must always match the counter ranges once running.
  phase_matches_count: assert property (@(posedge vga_clk) disable iff (!reset_n)
    armed |-> (h_phase == phase_of(hcnt, H_ACTIVE, H_FP, H_SYNC)) &&
              (v_phase == phase_of(vcnt, V_ACTIVE, V_FP, V_SYNC)));

endmodule
